// File: rtl/ycr1_slp_pkg.sv
// Shared state encoding and widths for the pipeline sleep controller.
package ycr1_slp_pkg;

  typedef enum logic [1:0] {
    SLP_RUN   = 2'b00,
    SLP_DRAIN = 2'b01,
    SLP_SLEEP = 2'b10,
    SLP_WAKE  = 2'b11
  } type_ycr1_slp_state_e;

  localparam int unsigned SLP_DRAIN_CNT_W = 8;

endpackage

// File: rtl/ycr1_slp_sat_cnt.sv
// Saturating up-counter with synchronous clear; used for sleep and drain cycle counts.
module ycr1_slp_sat_cnt #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             ctrl_rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  // Clear wins over increment; the count sticks at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {WIDTH{1'b1}})) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/ycr1_pipe_sleep_ctrl.sv
// WFI sleep sequencer: drains the pipe, requests clock gating, and wakes on irq/debug.
// Belongs to YCR1_CLKCTRL_EN builds; YCR1_WFI_TIMEOUT_EN adds a drain timeout.
module ycr1_pipe_sleep_ctrl
  import ycr1_slp_pkg::*;
#(
  parameter logic [7:0]  DRAIN_TO_CYC = 8'd255,
  parameter int unsigned SLP_CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 ctrl_rst_n,
  input  logic                 exu2slp_wfi_i,
  input  logic                 ifu2slp_idle_i,
  input  logic                 lsu2slp_idle_i,
  input  logic                 csr2slp_irq_pend_i,
  input  logic                 dbg2slp_halt_req_i,
  input  logic                 clkctl2pipe_clk_en_i,
  output logic                 pipe2clkctl_sleep_req_o,
  output logic                 pipe2clkctl_wake_req_o,
  output logic                 slp2ifu_fetch_stall_o,
  output logic [1:0]           slp_state_o,
  output logic [SLP_CNT_W-1:0] slp_cyc_cnt_o,
  output logic                 slp_drain_to_o
);

  type_ycr1_slp_state_e state;
  type_ycr1_slp_state_e state_next;
  logic                 wake;
  logic                 drain_to_hit;

  assign wake = csr2slp_irq_pend_i | dbg2slp_halt_req_i;

`ifdef YCR1_WFI_TIMEOUT_EN
  logic [SLP_DRAIN_CNT_W-1:0] drain_cnt;
  logic                       drain_to;

  ycr1_slp_sat_cnt #(
    .WIDTH (SLP_DRAIN_CNT_W)
  ) i_drain_cnt (
    .clk        (clk),
    .ctrl_rst_n (ctrl_rst_n),
    .clr        ((state_next == SLP_DRAIN) && (state != SLP_DRAIN)),
    .inc        (state == SLP_DRAIN),
    .cnt        (drain_cnt)
  );

  // Counter reads N-1 during the Nth DRAIN cycle, so exit after exactly DRAIN_TO_CYC cycles.
  assign drain_to_hit = (drain_cnt == (DRAIN_TO_CYC - 8'd1));

  always_ff @(posedge clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      drain_to <= 1'b0;
    end else if ((state == SLP_DRAIN) && !wake && !(ifu2slp_idle_i && lsu2slp_idle_i)
                 && drain_to_hit) begin
      drain_to <= 1'b1;
    end
  end

  assign slp_drain_to_o = drain_to;
`else
  assign drain_to_hit   = 1'b0;
  assign slp_drain_to_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      state <= SLP_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Wake outranks idle in DRAIN; WAKE runs to completion even if the wake source drops.
  always_comb begin
    state_next = state;
    case (state)
      SLP_RUN: begin
        if (exu2slp_wfi_i && !wake) state_next = SLP_DRAIN;
      end
      SLP_DRAIN: begin
        if (wake)                                  state_next = SLP_RUN;
        else if (ifu2slp_idle_i && lsu2slp_idle_i) state_next = SLP_SLEEP;
        else if (drain_to_hit)                     state_next = SLP_RUN;
      end
      SLP_SLEEP: begin
        if (wake) state_next = SLP_WAKE;
      end
      SLP_WAKE: begin
        if (clkctl2pipe_clk_en_i) state_next = SLP_RUN;
      end
      default: state_next = SLP_RUN;
    endcase
  end

  // Requests are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge ctrl_rst_n) begin
    if (!ctrl_rst_n) begin
      pipe2clkctl_sleep_req_o <= 1'b0;
      pipe2clkctl_wake_req_o  <= 1'b0;
    end else begin
      pipe2clkctl_sleep_req_o <= (state_next == SLP_SLEEP);
      pipe2clkctl_wake_req_o  <= (state_next == SLP_WAKE);
    end
  end

  ycr1_slp_sat_cnt #(
    .WIDTH (SLP_CNT_W)
  ) i_sleep_cnt (
    .clk        (clk),
    .ctrl_rst_n (ctrl_rst_n),
    .clr        ((state_next == SLP_SLEEP) && (state != SLP_SLEEP)),
    .inc        (state == SLP_SLEEP),
    .cnt        (slp_cyc_cnt_o)
  );

  assign slp2ifu_fetch_stall_o = (state != SLP_RUN);
  assign slp_state_o           = state;

endmodule

// File: tb/tb_ycr1_pipe_sleep_ctrl.sv
// Scoreboard bench for ycr1_pipe_sleep_ctrl; a 4-bit-counter copy checks saturation.
module tb_ycr1_pipe_sleep_ctrl;
  import ycr1_slp_pkg::*;

  logic        clk = 1'b0;
  logic        ctrl_rst_n = 1'b0;
  logic        wfi = 1'b0, irq = 1'b0, dbg = 1'b0;
  logic        ifu_idle = 1'b1, lsu_idle = 1'b1, clk_en = 1'b1;
  logic        sleep_req, wake_req, stall, drain_to;
  logic [1:0]  state;
  logic [31:0] cyc_cnt;
  logic        sleep_req4, wake_req4, stall4, drain_to4;
  logic [1:0]  state4;
  logic [3:0]  cyc_cnt4;

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic       sreq;
    logic       wreq;
    logic       stall;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ycr1_pipe_sleep_ctrl #(.DRAIN_TO_CYC(8'd8), .SLP_CNT_W(32)) dut (
    .clk(clk), .ctrl_rst_n(ctrl_rst_n), .exu2slp_wfi_i(wfi),
    .ifu2slp_idle_i(ifu_idle), .lsu2slp_idle_i(lsu_idle),
    .csr2slp_irq_pend_i(irq), .dbg2slp_halt_req_i(dbg),
    .clkctl2pipe_clk_en_i(clk_en), .pipe2clkctl_sleep_req_o(sleep_req),
    .pipe2clkctl_wake_req_o(wake_req), .slp2ifu_fetch_stall_o(stall),
    .slp_state_o(state), .slp_cyc_cnt_o(cyc_cnt), .slp_drain_to_o(drain_to)
  );

  ycr1_pipe_sleep_ctrl #(.DRAIN_TO_CYC(8'd8), .SLP_CNT_W(4)) dut4 (
    .clk(clk), .ctrl_rst_n(ctrl_rst_n), .exu2slp_wfi_i(wfi),
    .ifu2slp_idle_i(ifu_idle), .lsu2slp_idle_i(lsu_idle),
    .csr2slp_irq_pend_i(irq), .dbg2slp_halt_req_i(dbg),
    .clkctl2pipe_clk_en_i(clk_en), .pipe2clkctl_sleep_req_o(sleep_req4),
    .pipe2clkctl_wake_req_o(wake_req4), .slp2ifu_fetch_stall_o(stall4),
    .slp_state_o(state4), .slp_cyc_cnt_o(cyc_cnt4), .slp_drain_to_o(drain_to4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue what the DUT must show after the next edge.
  task automatic applyStimulus(input logic w, input logic i, input logic d, input logic fi,
                               input logic li, input logic ce, input string tag,
                               input logic [1:0] st, input logic sr, input logic wr,
                               input logic stl);
    @(negedge clk);
    wfi = w; irq = i; dbg = d; ifu_idle = fi; lsu_idle = li; clk_en = ce;
    exp_q.push_back('{tag, st, sr, wr, stl});
    @(posedge clk);
    #2;
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput({e.tag, ".state"}, 32'(state), 32'(e.st));
      checkOutput({e.tag, ".sleep_req"}, 32'(sleep_req), 32'(e.sreq));
      checkOutput({e.tag, ".wake_req"}, 32'(wake_req), 32'(e.wreq));
      checkOutput({e.tag, ".stall"}, 32'(stall), 32'(e.stall));
      checkOutput({e.tag, ".state_w4"}, 32'(state4), 32'(e.st));
    end
  end

  // Full WFI -> DRAIN -> SLEEP (n cycles) -> WAKE -> RUN sequence.
  task automatic runSleep(input int n, input logic ce_sleep);
    applyStimulus(1, 0, 0, 1, 1, 1, "wfi", SLP_DRAIN, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 1, 1, "enter_sleep", SLP_SLEEP, 1, 0, 1);
    for (int k = 1; k < n; k++)
      applyStimulus((k == 2), 0, 0, 1, 1, ce_sleep, "sleep_hold", SLP_SLEEP, 1, 0, 1);
    applyStimulus(0, 1, 0, 1, 1, ce_sleep, "wake_evt", SLP_WAKE, 0, 1, 1);
    if (!ce_sleep)
      applyStimulus(0, 0, 0, 1, 1, 0, "wake_hold", SLP_WAKE, 0, 1, 1);
    applyStimulus(0, 0, 0, 1, 1, 1, "wake_done", SLP_RUN, 0, 0, 0);
  endtask

  initial begin
    #3;
    checkOutput("rst.state", 32'(state), 0);
    checkOutput("rst.outs", {28'd0, sleep_req, wake_req, stall, drain_to}, 0);
    checkOutput("rst.cnt", cyc_cnt, 0);
    @(negedge clk);
    ctrl_rst_n = 1'b1;

    runSleep(7, 1'b0);
    checkOutput("cnt7", cyc_cnt, 7);

    applyStimulus(1, 1, 0, 1, 1, 1, "wfi_irq", SLP_RUN, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 1, 1, "wfi_irq_after", SLP_RUN, 0, 0, 0);
    applyStimulus(1, 0, 1, 1, 1, 1, "wfi_dbg", SLP_RUN, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 1, "idle_run", SLP_RUN, 0, 0, 0);

    applyStimulus(1, 0, 0, 1, 0, 1, "drain_wfi", SLP_DRAIN, 0, 0, 1);
    for (int k = 1; k < 5; k++)
      applyStimulus(0, 0, 0, 1, 0, 1, "drain_busy", SLP_DRAIN, 0, 0, 1);
    applyStimulus(0, 0, 1, 1, 0, 1, "drain_dbg", SLP_RUN, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      applyStimulus(0, 0, 0, 1, 0, 1, "drain_after", SLP_RUN, 0, 0, 0);
    checkOutput("cnt_held", cyc_cnt, 7);

    runSleep(20, 1'b0);
    checkOutput("cnt20", cyc_cnt, 20);
    checkOutput("cnt_sat4", 32'(cyc_cnt4), 15);

    runSleep(3, 1'b1);
    checkOutput("cnt3_fast", cyc_cnt, 3);

    applyStimulus(1, 0, 0, 1, 0, 1, "to_wfi", SLP_DRAIN, 0, 0, 1);
    for (int k = 1; k < 8; k++)
      applyStimulus(0, 0, 0, 1, 0, 1, "to_drain", SLP_DRAIN, 0, 0, 1);
`ifdef YCR1_WFI_TIMEOUT_EN
    applyStimulus(0, 0, 0, 1, 0, 1, "to_expire", SLP_RUN, 0, 0, 0);
    checkOutput("drain_to", 32'(drain_to), 1);
    applyStimulus(0, 0, 0, 1, 1, 1, "to_sticky", SLP_RUN, 0, 0, 0);
    checkOutput("drain_to_sticky", 32'(drain_to), 1);
`else
    applyStimulus(0, 0, 0, 1, 0, 1, "to_none", SLP_DRAIN, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 0, 1, "to_none2", SLP_DRAIN, 0, 0, 1);
    checkOutput("drain_to", 32'(drain_to), 0);
    applyStimulus(0, 1, 0, 1, 0, 1, "to_exit", SLP_RUN, 0, 0, 0);
`endif

    applyStimulus(1, 0, 0, 1, 1, 1, "rs_wfi", SLP_DRAIN, 0, 0, 1);
    applyStimulus(0, 0, 0, 1, 1, 1, "rs_sleep", SLP_SLEEP, 1, 0, 1);
    applyStimulus(0, 0, 0, 1, 1, 0, "rs_hold", SLP_SLEEP, 1, 0, 1);
    applyStimulus(0, 0, 0, 1, 1, 0, "rs_hold", SLP_SLEEP, 1, 0, 1);
    #1;
    ctrl_rst_n = 1'b0;
    clk_en = 1'b1;
    #1;
    checkOutput("mid_rst.state", 32'(state), 0);
    checkOutput("mid_rst.outs", {28'd0, sleep_req, wake_req, stall, drain_to}, 0);
    checkOutput("mid_rst.cnt", cyc_cnt, 0);
    @(negedge clk);
    ctrl_rst_n = 1'b1;
    runSleep(4, 1'b0);
    checkOutput("post_rst_cnt", cyc_cnt, 4);

    checkOutput("queue_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
